// File: rtl/pwm_pkg.sv
// Shared types and register-map offsets for the PWM bank, decoded from the 256-bit I2C register image.
package pwm_pkg;

  localparam int REG_W        = 8;
  localparam int IMAGE_W      = 256;
  localparam int CTRL_OFS     = 0;
  localparam int PRESCALE_OFS = 1;
  localparam int TOP_OFS      = 2;
  localparam int DUTY_OFS     = 3;

  typedef logic [REG_W-1:0] reg8_t;

  function automatic reg8_t get_reg(input logic [IMAGE_W-1:0] image, input int index);
    return image[index*REG_W +: REG_W];
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler and period counter for pwm_bank: produces cnt, the period boundary and the registered period_start pulse.
// With PWM_SHADOW_EN the wrap is an exact TOP match; without it TOP is live and the wrap is cnt >= TOP.
module pwm_timebase
  import pwm_pkg::*;
(
  input  logic  clock,
  input  logic  reset_n,
  input  logic  run,
  input  reg8_t prescale,
  input  reg8_t top,
  output reg8_t cnt,
  output logic  boundary,
  output logic  period_start
);

  reg8_t pc_q, pc_d;
  reg8_t cnt_q, cnt_d;
  logic  pending_q, pending_d;
  logic  period_start_q, period_start_d;
  logic  tick;
  logic  wrap;

  assign tick = run && (pc_q == prescale);

`ifdef PWM_SHADOW_EN
  assign wrap = (cnt_q == top);
`else
  assign wrap = (cnt_q >= top);
`endif

  assign boundary = tick && wrap;

  // pending marks the first cycle of a period: right after a wrap or after leaving idle
  always_comb begin
    pc_d           = pc_q + 8'd1;
    cnt_d          = cnt_q;
    pending_d      = boundary;
    period_start_d = run && pending_q;
    if (!run) begin
      pc_d      = '0;
      cnt_d     = '0;
      pending_d = 1'b1;
    end else if (tick) begin
      pc_d  = '0;
      cnt_d = wrap ? '0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q           <= '0;
      cnt_q          <= '0;
      pending_q      <= 1'b1;
      period_start_q <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      period_start_q <= period_start_d;
    end
  end

  assign cnt          = cnt_q;
  assign period_start = period_start_q;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM generator fed from the I2C register image (CTRL, PRESCALE, TOP, DUTY[c] at BASE_REG).
// PWM_SHADOW_EN: shadow PRESCALE/TOP/DUTY and update them only on period boundaries or while idle.
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int BASE_REG = 0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [IMAGE_W-1:0]   registers_packed,
  output logic [NUM_CH-1:0]    pwm,
  output logic                 period_start
);

  logic [NUM_CH-1:0] enable;
  logic [NUM_CH-1:0] invert;
  reg8_t             prescale_live;
  reg8_t             top_live;
  reg8_t             duty_live [NUM_CH];
  reg8_t             prescale_eff;
  reg8_t             top_eff;
  reg8_t             duty_eff [NUM_CH];
  logic              run;
  logic              boundary;
  reg8_t             cnt;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic              unused_image;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      enable[c]    = registers_packed[(BASE_REG + CTRL_OFS)*REG_W + c];
      invert[c]    = registers_packed[(BASE_REG + CTRL_OFS)*REG_W + NUM_CH + c];
      duty_live[c] = get_reg(registers_packed, BASE_REG + DUTY_OFS + c);
    end
    prescale_live = get_reg(registers_packed, BASE_REG + PRESCALE_OFS);
    top_live      = get_reg(registers_packed, BASE_REG + TOP_OFS);
  end

  // Registers outside this block's window are deliberately ignored
  assign unused_image = ^registers_packed;

  assign run = |enable;

  pwm_timebase u_timebase (
    .clock        (clock),
    .reset_n      (reset_n),
    .run          (run),
    .prescale     (prescale_eff),
    .top          (top_eff),
    .cnt          (cnt),
    .boundary     (boundary),
    .period_start (period_start)
  );

`ifdef PWM_SHADOW_EN
  reg8_t prescale_q, prescale_d;
  reg8_t top_q, top_d;
  reg8_t duty_q [NUM_CH];
  reg8_t duty_d [NUM_CH];
  logic  shadow_load;

  // Shadows track the live registers while idle so a restart begins with current values
  assign shadow_load = !run || boundary;

  always_comb begin
    prescale_d = prescale_q;
    top_d      = top_q;
    for (int c = 0; c < NUM_CH; c++) begin
      duty_d[c] = duty_q[c];
    end
    if (shadow_load) begin
      prescale_d = prescale_live;
      top_d      = top_live;
      for (int c = 0; c < NUM_CH; c++) begin
        duty_d[c] = duty_live[c];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prescale_q <= '0;
      top_q      <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        duty_q[c] <= '0;
      end
    end else begin
      prescale_q <= prescale_d;
      top_q      <= top_d;
      for (int c = 0; c < NUM_CH; c++) begin
        duty_q[c] <= duty_d[c];
      end
    end
  end

  assign prescale_eff = prescale_q;
  assign top_eff      = top_q;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      duty_eff[c] = duty_q[c];
    end
  end
`else
  logic unused_boundary;

  assign unused_boundary = boundary;
  assign prescale_eff    = prescale_live;
  assign top_eff         = top_live;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      duty_eff[c] = duty_live[c];
    end
  end
`endif

  // Enable and invert act live; a disabled channel is forced low regardless of invert
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      pwm_d[c] = enable[c] & ((cnt < duty_eff[c]) ^ invert[c]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: per-cycle comparison against a behavioural period model plus directed waveform measurements.
// Honours PWM_SHADOW_EN to select the shadowed or live-register model.
module tb_pwm_bank;

  localparam int NUM_CH   = 2;
  localparam int BASE_REG = 5;
  localparam int CTRL_OFS = 0;
  localparam int PRE_OFS  = 1;
  localparam int TOP_OFS  = 2;
  localparam int DUTY_OFS = 3;

  logic              clock = 1'b0;
  logic              resetN = 1'b0;
  logic [255:0]      registersPacked = '0;
  logic [NUM_CH-1:0] pwm;
  logic              periodStart;

  int checkCount = 0;
  int failCount  = 0;

  // Reference model state
  int                mPc = 0;
  int                mCnt = 0;
  bit                mPending = 1'b1;
  logic [NUM_CH-1:0] expPwm = '0;
  logic              expPs = 1'b0;
`ifdef PWM_SHADOW_EN
  int                sPre = 0;
  int                sTop = 0;
  int                sDuty [NUM_CH] = '{default: 0};
`endif

  pwm_bank #(.NUM_CH(NUM_CH), .BASE_REG(BASE_REG)) dut (
    .clock            (clock),
    .reset_n          (resetN),
    .registers_packed (registersPacked),
    .pwm              (pwm),
    .period_start     (periodStart)
  );

  always #5 clock = ~clock;

  function automatic int getReg(input int ofs);
    return int'(registersPacked[(BASE_REG + ofs)*8 +: 8]);
  endfunction

  task automatic setReg(input int ofs, input logic [7:0] val);
    registersPacked[(BASE_REG + ofs)*8 +: 8] = val;
  endtask

  task automatic modelReset();
    mPc      = 0;
    mCnt     = 0;
    mPending = 1'b1;
    expPwm   = '0;
    expPs    = 1'b0;
`ifdef PWM_SHADOW_EN
    sPre = 0;
    sTop = 0;
    for (int c = 0; c < NUM_CH; c++) sDuty[c] = 0;
`endif
  endtask

  // One clock of the PWM rules: outputs come from the state before the edge, then the period advances
  task automatic modelStep();
    int ctrl, en, inv, pre, top;
    int duty [NUM_CH];
    bit run, atBoundary;
    ctrl = getReg(CTRL_OFS);
    en   = ctrl % (1 << NUM_CH);
    inv  = (ctrl >> NUM_CH) % (1 << NUM_CH);
    run  = (en != 0);
`ifdef PWM_SHADOW_EN
    pre = sPre;
    top = sTop;
    for (int c = 0; c < NUM_CH; c++) duty[c] = sDuty[c];
`else
    pre = getReg(PRE_OFS);
    top = getReg(TOP_OFS);
    for (int c = 0; c < NUM_CH; c++) duty[c] = getReg(DUTY_OFS + c);
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      expPwm[c] = (((en >> c) & 1) == 1) && ((mCnt < duty[c]) != (((inv >> c) & 1) == 1));
    end
    expPs = run && mPending;
    atBoundary = 1'b0;
    if (!run) begin
      mPc      = 0;
      mCnt     = 0;
      mPending = 1'b1;
    end else begin
      if (mPc == pre) begin
`ifdef PWM_SHADOW_EN
        atBoundary = (mCnt == top);
`else
        atBoundary = (mCnt >= top);
`endif
        mPc  = 0;
        mCnt = atBoundary ? 0 : mCnt + 1;
      end else begin
        mPc = (mPc + 1) % 256;
      end
      mPending = atBoundary;
    end
`ifdef PWM_SHADOW_EN
    if (!run || atBoundary) begin
      sPre = getReg(PRE_OFS);
      sTop = getReg(TOP_OFS);
      for (int c = 0; c < NUM_CH; c++) sDuty[c] = getReg(DUTY_OFS + c);
    end
`endif
  endtask

  initial begin
    forever begin
      @(posedge clock or negedge resetN);
      if (!resetN) modelReset();
      else modelStep();
    end
  end

  task automatic checkOutput();
    checkCount++;
    if (pwm !== expPwm) begin
      failCount++;
      $display("[TB] FAIL pwm @%0t: got %b, expected %b", $time, pwm, expPwm);
    end
    checkCount++;
    if (periodStart !== expPs) begin
      failCount++;
      $display("[TB] FAIL period_start @%0t: got %b, expected %b", $time, periodStart, expPs);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s @%0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(negedge clock);
      checkOutput();
    end
  endtask

  task automatic measure(input int n, output int psCount, output int highs0, output int highs1);
    psCount = 0;
    highs0  = 0;
    highs1  = 0;
    repeat (n) begin
      @(negedge clock);
      checkOutput();
      psCount += int'(periodStart);
      highs0  += int'(pwm[0]);
      highs1  += int'(pwm[1]);
    end
  endtask

  task automatic waitStart(input int bound);
    bit found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clock);
      checkOutput();
      found = (periodStart === 1'b1);
    end
    checkValue("waitStart found", int'(found), 1);
  endtask

  // Called on a period_start cycle; counts cycles and pwm[0] highs up to the next period_start
  task automatic measurePeriod(output int len, output int highs0);
    bit seen = 1'b0;
    len    = 0;
    highs0 = int'(pwm[0]);
    while (!seen && len < 600) begin
      @(negedge clock);
      checkOutput();
      len++;
      if (periodStart === 1'b1) seen = 1'b1;
      else highs0 += int'(pwm[0]);
    end
    checkValue("measurePeriod found", int'(seen), 1);
  endtask

  // Loads the data registers while idle, then enables, so the first period uses them
  task automatic applyStimulus(input logic [7:0] ctrl, input logic [7:0] pre, input logic [7:0] top,
                               input logic [7:0] d0, input logic [7:0] d1);
    setReg(CTRL_OFS, 8'h00);
    setReg(PRE_OFS, pre);
    setReg(TOP_OFS, top);
    setReg(DUTY_OFS, d0);
    setReg(DUTY_OFS + 1, d1);
    stepCycles(2);
    setReg(CTRL_OFS, ctrl);
  endtask

  task automatic randomPhase();
    for (int it = 0; it < 700; it++) begin
      case ($urandom_range(0, 9))
        0, 1: setReg(CTRL_OFS, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
        2, 3: setReg(DUTY_OFS + int'($urandom_range(0, NUM_CH - 1)),
                     ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12)));
        4:    setReg(TOP_OFS, 8'($urandom_range(0, 12)));
        5:    setReg(PRE_OFS, 8'($urandom_range(0, 3)));
        6: begin
          resetN = 1'b0;
          #2;
          resetN = 1'b1;
        end
        7: begin
          setReg(CTRL_OFS, 8'($urandom_range(0, 15)));
          setReg(TOP_OFS, 8'($urandom_range(0, 10)));
          setReg(DUTY_OFS, 8'($urandom_range(0, 11)));
          setReg(PRE_OFS, 8'($urandom_range(0, 2)));
        end
        default: ;
      endcase
      stepCycles(int'($urandom_range(1, 16)));
    end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got still running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ps, h0, h1, len;
    $display("[TB] starting pwm_bank bench");
    resetN = 1'b0;
    stepCycles(3);
    checkValue("reset pwm", int'(pwm), 0);
    checkValue("reset period_start", int'(periodStart), 0);
    resetN = 1'b1;
    stepCycles(4);
    checkValue("idle pwm", int'(pwm), 0);

    // Basic duty: TOP=9, DUTY0=3 -> 3 high of every 10
    applyStimulus(8'h01, 8'd0, 8'd9, 8'd3, 8'd0);
    stepCycles(12);
    measure(30, ps, h0, h1);
    checkValue("basic period_start count", ps, 3);
    checkValue("basic pwm0 highs", h0, 9);
    checkValue("basic pwm1 highs", h1, 0);
    waitStart(20);
    measurePeriod(len, h0);
    checkValue("basic period length", len, 10);
    checkValue("basic highs per period", h0, 3);

    // Prescale 3, TOP 4 -> 20-clock period; DUTY 0 and DUTY > TOP give constant levels
    applyStimulus(8'h03, 8'd3, 8'd4, 8'd0, 8'd7);
    stepCycles(5);
    measure(40, ps, h0, h1);
    checkValue("prescale period_start count", ps, 2);
    checkValue("prescale pwm0 highs", h0, 0);
    checkValue("prescale pwm1 highs", h1, 40);
    waitStart(40);
    measurePeriod(len, h0);
    checkValue("prescale period length", len, 20);

    // Invert channel 0
    applyStimulus(8'h05, 8'd0, 8'd9, 8'd3, 8'd0);
    stepCycles(12);
    measure(30, ps, h0, h1);
    checkValue("invert period_start count", ps, 3);
    checkValue("invert pwm0 highs", h0, 21);
    checkValue("invert pwm1 highs", h1, 0);

    // DUTY0 3 -> 8 written while cnt=5
    applyStimulus(8'h01, 8'd0, 8'd9, 8'd3, 8'd0);
    stepCycles(12);
    waitStart(20);
    h0 = int'(pwm[0]);
    for (int i = 1; i < 10; i++) begin
      @(negedge clock);
      checkOutput();
      h0 += int'(pwm[0]);
      if (i == 4) setReg(DUTY_OFS, 8'd8);
    end
`ifdef PWM_SHADOW_EN
    checkValue("update current period highs", h0, 3);
`else
    checkValue("update current period highs", h0, 6);
`endif
    measure(10, ps, h0, h1);
    checkValue("update next period_start", ps, 1);
    checkValue("update next period highs", h0, 8);

    // TOP=0, PRESCALE=2: constant high, period_start every 3 clocks
    applyStimulus(8'h01, 8'd2, 8'd0, 8'd1, 8'd0);
    stepCycles(6);
    measure(30, ps, h0, h1);
    checkValue("top0 period_start count", ps, 10);
    checkValue("top0 pwm0 highs", h0, 30);

    // Disable mid-period, then re-enable
    applyStimulus(8'h01, 8'd0, 8'd9, 8'd3, 8'd0);
    stepCycles(15);
    setReg(CTRL_OFS, 8'h00);
    stepCycles(2);
    checkValue("disable pwm", int'(pwm), 0);
    checkValue("disable period_start", int'(periodStart), 0);
    setReg(CTRL_OFS, 8'h01);
    waitStart(3);
    measurePeriod(len, h0);
    checkValue("reenable period length", len, 10);
    checkValue("reenable highs", h0, 3);

    // Asynchronous reset mid-period
    applyStimulus(8'h03, 8'd1, 8'd6, 8'd2, 8'd5);
    stepCycles(9);
    resetN = 1'b0;
    setReg(CTRL_OFS, 8'h00);
    #1;
    checkValue("async reset pwm", int'(pwm), 0);
    checkValue("async reset period_start", int'(periodStart), 0);
    stepCycles(2);
    resetN = 1'b1;
    stepCycles(5);
    checkValue("post-reset idle pwm", int'(pwm), 0);
    checkValue("post-reset idle period_start", int'(periodStart), 0);

    randomPhase();

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
